// File: rtl/serial_rx_pkg.sv
// Shared types and sizing helpers for the serial word receiver.
// State encoding, default word width and the bit-counter width function.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Counter must hold values 0..frame_bits inclusive.
  function automatic int unsigned cnt_width(input int unsigned frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Right-shifting deserialiser and bit counter for serial_word_rx.
// restart takes the current bit as bit 0 of a new frame; data bits beyond WIDTH (parity) are counted only.
module serial_rx_shifter
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned FRAME_BITS = WIDTH,
  parameter int unsigned CNT_W      = cnt_width(FRAME_BITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_en,
  input  logic             s_in,
  input  logic             restart,
  output logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (restart) begin
      // After WIDTH right shifts this bit lands at word[0], so stale contents need no clearing.
      word <= {s_in, word[WIDTH-1:1]};
      cnt  <= CNT_W'(1);
    end else if (s_en) begin
      if (cnt < CNT_W'(WIDTH)) begin
        word <= {s_in, word[WIDTH-1:1]};
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// LSB-first serial-to-parallel word receiver with a one-entry valid/ready output buffer.
// Optional even-parity bit per frame when SERIAL_WORD_RX_PARITY_EN is defined (adds parity_err port).
module serial_word_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_en,
  input  logic             s_in,
  input  logic             s_start,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
`ifdef SERIAL_WORD_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SERIAL_WORD_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
  localparam int unsigned FRAME_BITS = WIDTH;
`endif
  localparam int unsigned CNT_W = cnt_width(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  state_t           state, state_next;
  logic             restart, frame_break, completing, shift_en;
  logic             word_ok, load, drop;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    restart     = 1'b0;
    frame_break = 1'b0;
    completing  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (s_en && s_start) begin
          restart    = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (s_en) begin
          if (s_start) begin
            restart     = 1'b1;
            frame_break = 1'b1;
          end else if (cnt == LAST_CNT) begin
            completing = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign shift_en = restart || (state == SHIFT && s_en);

  serial_rx_shifter #(
    .WIDTH      (WIDTH),
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_en    (shift_en),
    .s_in    (s_in),
    .restart (restart),
    .word    (word),
    .cnt     (cnt)
  );

`ifdef SERIAL_WORD_RX_PARITY_EN
  logic par_bad;

  // The parity bit is not shifted in, so word holds only data when it arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          par_bad <= 1'b0;
    else if (completing) par_bad <= (^word) ^ s_in;
  end

  assign word_ok = !par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               parity_err <= 1'b0;
    else if (state == DONE && par_bad)        parity_err <= 1'b1;
    else if (err_clr)                         parity_err <= 1'b0;
  end
`else
  assign word_ok = 1'b1;
`endif

  // A drain in the DONE cycle frees the slot, so the new word loads instead of overrunning.
  assign load = (state == DONE) && word_ok && (!p_valid || p_ready);
  assign drop = (state == DONE) && word_ok && p_valid && !p_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_out   <= '0;
      p_valid <= 1'b0;
    end else if (load) begin
      p_out   <= word;
      p_valid <= 1'b1;
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

  // Set events take priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)             overrun <= 1'b1;
      else if (err_clr)     overrun <= 1'b0;
      if (frame_break)      frame_err <= 1'b1;
      else if (err_clr)     frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx: directed scenarios plus randomized frames against a bit-level model.
// Builds with or without SERIAL_WORD_RX_PARITY_EN.
module tb_serial_word_rx;

  localparam int W = 32;
`ifdef SERIAL_WORD_RX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         s_en = 1'b0, s_in = 1'b0, s_start = 1'b0;
  logic         p_ready = 1'b0, err_clr = 1'b0;
  logic [W-1:0] p_out;
  logic         p_valid, overrun, frame_err;
`ifdef SERIAL_WORD_RX_PARITY_EN
  logic         parity_err;
`endif

  serial_word_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_en      (s_en),
    .s_in      (s_in),
    .s_start   (s_start),
    .p_out     (p_out),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .err_clr   (err_clr)
`ifdef SERIAL_WORD_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_ready = 1'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are collected as a list of bits, buffer/flags follow the handshake rules.
  logic [W-1:0] exp_q[$];
  bit           m_valid, m_ovr, m_fe, m_par;
  bit           in_frame, pend_done, pend_ok, par_acc;
  int           nb;
  logic [W-1:0] acc, pend_word;

  task automatic model_reset();
    m_valid = 0; m_ovr = 0; m_fe = 0; m_par = 0;
    in_frame = 0; pend_done = 0; pend_ok = 0; par_acc = 0;
    nb = 0; acc = '0; pend_word = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit set_ovr, set_fe, set_par, load, drain, done_now;
    set_ovr = 0; set_fe = 0; set_par = 0; load = 0;
    drain    = m_valid && p_ready;
    done_now = pend_done;
    pend_done = 0;
    if (done_now) begin
      if (!pend_ok)                 set_par = 1;
      else if (!m_valid || p_ready) load = 1;
      else                          set_ovr = 1;
    end
    if (load) begin
      m_valid = 1;
      exp_q.push_back(pend_word);
    end else if (drain) begin
      m_valid = 0;
    end
    if (s_en) begin
      if (s_start) begin
        set_fe   = in_frame;
        in_frame = 1;
        nb       = 1;
        acc      = '0;
        acc[0]   = s_in;
        par_acc  = s_in;
      end else if (in_frame) begin
        if (nb < W) acc[nb] = s_in;
        par_acc = par_acc ^ s_in;
        nb++;
        if (nb == FRAME) begin
          in_frame  = 0;
          pend_done = 1;
          pend_word = acc;
          pend_ok   = (FRAME == W) || !par_acc;
        end
      end
    end
    m_ovr = set_ovr || (m_ovr && !err_clr);
    m_fe  = set_fe  || (m_fe  && !err_clr);
    m_par = set_par || (m_par && !err_clr);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Monitor: compare status every cycle, pop the scoreboard on each transfer.
  initial begin
    logic [W-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_bit("mon_p_valid", p_valid, m_valid);
        check_bit("mon_overrun", overrun, m_ovr);
        check_bit("mon_frame_err", frame_err, m_fe);
`ifdef SERIAL_WORD_RX_PARITY_EN
        check_bit("mon_parity_err", parity_err, m_par);
`endif
        if (p_valid && p_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %h, required no transfer (t=%0t)", p_out, $time);
          end else begin
            exp_w = exp_q.pop_front();
            check_word("mon_p_out", p_out, exp_w);
          end
        end
      end
    end
  end

  task automatic step(input logic en, input logic start, input logic b);
    s_en    = en;
    s_start = start;
    s_in    = b;
    if (rand_ready) begin
      p_ready = 1'($urandom_range(0, 1));
      err_clr = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit sparse, input bit bad_par);
    logic p;
    p = (^w) ^ bad_par;
    for (int i = 0; i < FRAME; i++) begin
      if (sparse) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, i == 0, (i < W) ? w[i] : p);
    end
    s_en    = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) step(1'b1, i == 0, 1'($urandom_range(0, 1)));
    s_en    = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_word("reset_p_out", p_out, '0);
    check_bit("reset_p_valid", p_valid, 1'b0);
    check_bit("reset_overrun", overrun, 1'b0);
    check_bit("reset_frame_err", frame_err, 1'b0);

    // Single word: DONE cycle, then one valid cycle.
    p_ready = 1'b1;
    send_frame(32'hDEADBEEF, 1'b0, 1'b0);
    check_bit("single_done_cycle_valid", p_valid, 1'b0);
    @(posedge clk); #1;
    check_bit("single_valid_rise", p_valid, 1'b1);
    check_word("single_p_out", p_out, 32'hDEADBEEF);
    @(posedge clk); #1;
    check_bit("single_valid_fall", p_valid, 1'b0);

    // Backpressure and overrun.
    p_ready = 1'b0;
    send_frame(32'h00000001, 1'b0, 1'b0);
    idle(2);
    send_frame(32'h80000000, 1'b0, 1'b0);
    idle(2);
    check_word("ovr_p_out_held", p_out, 32'h00000001);
    check_bit("ovr_p_valid_held", p_valid, 1'b1);
    check_bit("ovr_flag", overrun, 1'b1);
    p_ready = 1'b1;
    @(posedge clk); #1;
    p_ready = 1'b0;
    check_bit("ovr_drained", p_valid, 1'b0);
    pulse_clr();
    check_bit("ovr_cleared", overrun, 1'b0);

    // Drain and complete in the same cycle.
    send_frame(32'hCAFEF00D, 1'b0, 1'b0);
    idle(2);
    send_frame(32'h12345678, 1'b0, 1'b0);
    p_ready = 1'b1;
    @(posedge clk); #1;
    p_ready = 1'b0;
    check_word("same_cycle_p_out", p_out, 32'h12345678);
    check_bit("same_cycle_valid", p_valid, 1'b1);
    check_bit("same_cycle_no_ovr", overrun, 1'b0);
    p_ready = 1'b1;
    idle(1);

    // Restart after 10 bits.
    send_partial(10);
    send_frame(32'hA5A5A5A5, 1'b0, 1'b0);
    idle(2);
    check_bit("restart_frame_err", frame_err, 1'b1);
    check_word("restart_p_out", p_out, 32'hA5A5A5A5);
    pulse_clr();
    check_bit("restart_err_cleared", frame_err, 1'b0);

    // Sparse strobe.
    send_frame(32'hFFFFFFFF, 1'b1, 1'b0);
    idle(2);
    check_word("sparse_p_out", p_out, 32'hFFFFFFFF);

`ifdef SERIAL_WORD_RX_PARITY_EN
    p_ready = 1'b0;
    send_frame(32'h0F0F1234, 1'b0, 1'b1);
    idle(2);
    check_bit("parity_dropped", p_valid, 1'b0);
    check_bit("parity_err_set", parity_err, 1'b1);
    pulse_clr();
    check_bit("parity_err_cleared", parity_err, 1'b0);
    p_ready = 1'b1;
`endif

    // Back-to-back frames with s_en held high.
    for (int i = 0; i < 3; i++) send_frame($urandom, 1'b0, 1'b0);
    idle(3);

    // Asynchronous reset mid-frame with a buffered word and a raised flag.
    p_ready = 1'b0;
    send_frame($urandom, 1'b0, 1'b0);
    send_partial(5);
    send_frame($urandom, 1'b0, 1'b0);
    idle(2);
    send_partial(5);
    #2 rst_n = 1'b0;
    #1;
    check_word("async_rst_p_out", p_out, '0);
    check_bit("async_rst_p_valid", p_valid, 1'b0);
    check_bit("async_rst_overrun", overrun, 1'b0);
    check_bit("async_rst_frame_err", frame_err, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    p_ready = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    idle(2);
    check_bit("post_rst_no_valid", p_valid, 1'b0);

    // Randomized traffic, handshake and error clears.
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      w = $urandom;
      if ($urandom_range(0, 9) == 0) send_partial($urandom_range(1, FRAME - 1));
      send_frame(w, $urandom_range(0, 4) == 0, (FRAME != W) && ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    err_clr    = 1'b0;
    p_ready    = 1'b1;
    idle(5);
    check_bit("scoreboard_empty", exp_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver that deserialises an LSB-first bitstream into 32-bit words. It is the receiving end of the team's parallel-load/serial-shift word transmitter, which shifts right and emits bit 0 first. Bits are qualified by a strobe and framed by a start flag. Completed words are held in a one-entry output buffer and drained through a valid/ready handshake, with sticky error flags for overrun and broken frames.

## Interface
- WIDTH, 32, word length in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- s_en  input  1  serial bit strobe; s_in is sampled only when high.
- s_in  input  1  serial data bit.
- s_start  input  1  frame start; qualified by s_en and marks the current bit as bit 0.
- p_out  output  WIDTH  received word; meaningful while p_valid is high.
- p_valid  output  1  output buffer holds a word.
- p_ready  input  1  consumer accepts; a transfer occurs when p_valid && p_ready.
- overrun  output  1  sticky; a completed word was dropped because the buffer was full.
- frame_err  output  1  sticky; a frame was restarted before it completed.
- err_clr  input  1  synchronous clear of overrun and frame_err.

## Operation
- FSM states:
  - IDLE: waiting for a frame. s_en && s_start loads bit 0 and moves to SHIFT with cnt=1. s_en without s_start is ignored.
  - SHIFT: each s_en shifts the shift register right as sh <= {s_in, sh[WIDTH-1:1]} and increments cnt. This places the first-received bit at p_out[0].
- Frame complete: on the s_en that brings cnt to WIDTH, go to DONE for one cycle, then to IDLE. An s_start arriving in DONE is handled as in IDLE.
- In DONE:
  - If the buffer is empty, or is being drained in the same cycle, the word is loaded into p_out and p_valid is set.
  - Otherwise the word is dropped, overrun is set, and p_out is unchanged.
- s_start during SHIFT: the partial word is discarded, frame_err is set, and the current bit is taken as bit 0 of a new frame with cnt=1.
- Buffer drain: p_valid && p_ready clears p_valid. p_out keeps its last value.
- err_clr clears both sticky flags. A set event in the same cycle wins over the clear.
- cnt is $clog2(WIDTH+1) bits wide. It is never compared above WIDTH.

## Timing
- Reset values: p_out=0, p_valid=0, overrun=0, frame_err=0, FSM=IDLE, cnt=0, sh=0.
- Latency: the last bit is sampled at edge N. DONE is entered at edge N, and p_valid rises at edge N+1.
- Throughput: with s_en held high, one word per WIDTH cycles. DONE overlaps bit 0 of the next frame, so back-to-back frames lose no bits.
- Handshake:
  - p_out and p_valid are stable while p_valid && !p_ready.
  - p_ready may be high while p_valid is low.
  - p_valid has no combinational dependency on p_ready.
- Asynchronous reset mid-frame: all state is cleared immediately. The partial word is lost, and no error flag is raised.

## Configuration
- SERIAL_WORD_RX_PARITY_EN:
  - When defined, each frame carries WIDTH+1 bits; the final bit is even parity over the data bits.
    - Completion happens at cnt==WIDTH+1, and cnt widens accordingly.
    - On a parity mismatch the word is dropped, not buffered, and the additional sticky output parity_err is set; err_clr also clears parity_err.
  - When undefined, frames are WIDTH bits and the parity_err port does not exist.

## Structure
- Shared package serial_rx_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the default word width constant (32);
  - a localparam function for the counter width.
- One sub-module, serial_rx_shifter:
  - contains the shift register and bit counter;
  - inputs: clk, rst_n, s_en, s_in, restart;
  - outputs: word, cnt.
- The top level holds the FSM, the output buffer and the error flags.

## Test plan
- Reset check: assert rst_n=0 mid-frame. All outputs go to 0 immediately; after release, no p_valid appears until a new s_start.
- Single word: send 0xDEADBEEF LSB-first with s_en=1 continuously and p_ready=1. p_valid rises one cycle after bit 31, with p_out=0xDEADBEEF, and falls after one cycle.
- Backpressure and overrun: hold p_ready=0 and send 0x00000001 then 0x80000000. p_out stays 0x00000001 and overrun=1. After p_ready=1 for one cycle, p_valid=0.
- Drain and complete in the same cycle: assert p_ready exactly in the DONE cycle of word 2. Word 2 (0x12345678) is loaded and overrun stays 0.
- Restart: after 10 bits, assert s_start, then send 0xA5A5A5A5. frame_err=1 and p_out=0xA5A5A5A5. After err_clr, frame_err=0.
- Sparse strobe and parity: with s_en toggling every other cycle, 0xFFFFFFFF is received correctly. With SERIAL_WORD_RX_PARITY_EN defined, a bad parity bit gives p_valid=0 and parity_err=1.
